rstseq_ctrl: RTL and testbench

RSTSEQ_CTRL -- requirements
Module: rstseq_ctrl

---
 rtl/rstseq_ctrl.sv | 155 +++++++++++++++
 tb/tb_rstseq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rstseq_ctrl.sv
// Reset sequencer: releases NumDomains active-low resets one at a time, in ascending order, each after the previous domain acknowledges.
// Optional ack timeout with sticky err_o when RSTSEQ_ACK_TIMEOUT_EN is defined; otherwise err_o is tied low.
//
// state      | meaning
// S_HOLD     | all domain resets asserted, hold counter running
// S_RELEASE  | release domain idx on the next edge
// S_WAIT_ACK | waiting for dom_ack_i[idx] (or timeout)
// S_GAP      | idle gap before the next release
// S_DONE     | every domain released and acknowledged
module rstseq_ctrl #(
  parameter int NumDomains    = 4,
  parameter int HoldCycles    = 8,
  parameter int GapCycles     = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  test_mode_i,
  input  logic                  sw_rst_req_i,
  input  logic [NumDomains-1:0] dom_ack_i,
  output logic [NumDomains-1:0] dom_rst_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int MaxHg  = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int MaxCyc = (MaxHg > TimeoutCycles) ? MaxHg : TimeoutCycles;
  localparam int CntW   = $clog2(MaxCyc) + 1;
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_RELEASE  = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NumDomains-1:0]   dom_q, dom_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout;
  logic                    ack_ok;

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeLast = CntW'(TimeoutCycles - 1);
  logic err_q;

  assign timeout = (state_q == S_WAIT_ACK) && (cnt_q == TimeLast);

  // Sticky until the next software re-sequence or reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (sw_rst_req_i) begin
      err_q <= 1'b0;
    end else if (timeout && !dom_ack_i[idx_q]) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign ack_ok = dom_ack_i[idx_q] | timeout;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (sw_rst_req_i) begin
      state_d = S_HOLD;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HoldLast) begin
            state_d = S_RELEASE;
            idx_d   = '0;
          end
        end
        S_RELEASE: state_d = S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (ack_ok) begin
            if (idx_q == IdxLast) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = (GapCycles == 0) ? S_RELEASE : S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GapLast) state_d = S_RELEASE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_HOLD;
      endcase
    end
    // One shared counter, restarted on every state change and saturating so it never wraps.
    if (sw_rst_req_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    dom_d = dom_q;
    if (sw_rst_req_i) begin
      dom_d = '0;
    end else if (state_q == S_RELEASE) begin
      dom_d[idx_q] = 1'b1;
    end
    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Test bypass overrides the registered outputs; the sequencer keeps running underneath.
  assign dom_rst_no = test_mode_i ? {NumDomains{rst_n}} : dom_q;
  assign busy_o     = busy_q & ~test_mode_i;
  assign done_o     = done_q | test_mode_i;

endmodule

// File: tb/tb_rstseq_ctrl.sv
// Directed self-checking bench for rstseq_ctrl (4 domains, hold 8, gap 4, timeout 16) plus a gap-0 instance.
// Expectations follow RSTSEQ_ACK_TIMEOUT_EN when the build defines it.
module tb_rstseq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_mode = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] dom_ack;
  logic [3:0] dom_rst_no;
  logic       busy, done, err;

  logic       tie0 = 1'b0;
  logic [3:0] g0_rst_no;
  logic       g0_busy, g0_done, g0_err;

  logic [3:0] ack_q = 4'b0000;
  logic [3:0] ack_mask = 4'b1111;
  logic [3:0] ack_force = 4'b0000;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  always #5 clk_i = ~clk_i;

  // Domain model: acknowledge one register stage after its reset is released.
  always @(posedge clk_i) ack_q <= dom_rst_no;
  assign dom_ack = (ack_q | ack_force) & ack_mask;

  rstseq_ctrl #(
    .NumDomains(4), .HoldCycles(8), .GapCycles(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .test_mode_i(test_mode), .sw_rst_req_i(sw_rst_req),
    .dom_ack_i(dom_ack), .dom_rst_no(dom_rst_no), .busy_o(busy), .done_o(done), .err_o(err)
  );

  rstseq_ctrl #(
    .NumDomains(4), .HoldCycles(8), .GapCycles(0), .TimeoutCycles(16)
  ) dut_g0 (
    .clk_i(clk_i), .rst_n(rst_n), .test_mode_i(tie0), .sw_rst_req_i(tie0),
    .dom_ack_i(g0_rst_no), .dom_rst_no(g0_rst_no), .busy_o(g0_busy), .done_o(g0_done), .err_o(g0_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(posedge clk_i);
      edge_n++;
    end
    #1;
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    @(posedge clk_i);
    #1;
    sw_rst_req = 1'b0;
    edge_n = 0;
  endtask

  // Full nominal sequence measured from the edge HOLD was (re)entered.
  task automatic nominal(input bit with_g0);
    step_to(8);  chk("hold_e8", dom_rst_no, 4'b0000);
    step_to(9);  chk("rel0_e9", dom_rst_no, 4'b0001);
    if (with_g0) chk("g0_e9", g0_rst_no, 4'b0001);
    step_to(10); if (with_g0) chk("g0_e10", g0_rst_no, 4'b0001);
    step_to(11); if (with_g0) chk("g0_e11", g0_rst_no, 4'b0011);
    step_to(13); if (with_g0) chk("g0_e13", g0_rst_no, 4'b0111);
    step_to(15);
    chk("e15", dom_rst_no, 4'b0001);
    if (with_g0) chk("g0_e15", g0_rst_no, 4'b1111);
    step_to(16);
    chk("rel1_e16", dom_rst_no, 4'b0011);
    if (with_g0) begin
      chk("g0_done_e16", g0_done, 1'b1);
      chk("g0_err", g0_err, 1'b0);
    end
    step_to(22); chk("e22", dom_rst_no, 4'b0011);
    step_to(23); chk("rel2_e23", dom_rst_no, 4'b0111);
    step_to(29); chk("e29", dom_rst_no, 4'b0111);
    step_to(30); chk("rel3_e30", dom_rst_no, 4'b1111);
    step_to(31); chk("done_e31", done, 1'b0); chk("busy_e31", busy, 1'b1);
    step_to(32); chk("done_e32", done, 1'b1); chk("busy_e32", busy, 1'b0);
    chk("err_nom", err, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dom", dom_rst_no, 4'b0000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk_i);
    rst_n = 1'b1;
    edge_n = 0;
    nominal(1'b1);

    // Software re-sequence from DONE replays identically
    step_to(40);
    sw_pulse();
    chk("sw_dom", dom_rst_no, 4'b0000);
    chk("sw_done", done, 1'b0);
    chk("sw_busy", busy, 1'b1);
    nominal(1'b0);

    // Held request keeps HOLD reloaded; stuck-high acks on unreleased domains ignored
    ack_force = 4'b1111;
    sw_rst_req = 1'b1;
    edge_n = 0;
    step_to(20);
    chk("swhold_dom", dom_rst_no, 4'b0000);
    chk("swhold_busy", busy, 1'b1);
    sw_rst_req = 1'b0;
    edge_n = 0;
    step_to(8);  chk("stk_e8", dom_rst_no, 4'b0000);
    step_to(9);  chk("stk_e9", dom_rst_no, 4'b0001);
    step_to(14); chk("stk_e14", dom_rst_no, 4'b0001);
    step_to(15); chk("stk_e15", dom_rst_no, 4'b0011);
    ack_force = 4'b0000;

    // Domain 2 never acknowledges
    ack_mask = 4'b1011;
    sw_pulse();
    step_to(23); chk("to_rel2", dom_rst_no, 4'b0111);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    step_to(38); chk("to_err_e38", err, 1'b0);
    step_to(39); chk("to_err_e39", err, 1'b1);
    step_to(43); chk("to_e43", dom_rst_no, 4'b0111);
    step_to(44); chk("to_rel3_e44", dom_rst_no, 4'b1111);
    step_to(45); chk("to_done_e45", done, 1'b0);
    step_to(46); chk("to_done_e46", done, 1'b1); chk("to_err_e46", err, 1'b1);
`else
    step_to(60);
    chk("noto_dom", dom_rst_no, 4'b0111);
    chk("noto_err", err, 1'b0);
    chk("noto_busy", busy, 1'b1);
    chk("noto_done", done, 1'b0);
`endif
    ack_mask = 4'b1111;

    // Asynchronous reset mid-sequence
    sw_pulse();
    chk("clr_err", err, 1'b0);
    step_to(17); chk("mid_dom", dom_rst_no, 4'b0011);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dom", dom_rst_no, 4'b0000);
    chk("arst_busy", busy, 1'b1);
    chk("arst_done", done, 1'b0);

    // Test bypass
    test_mode = 1'b1;
    #1;
    chk("tm_lo_dom", dom_rst_no, 4'b0000);
    chk("tm_done", done, 1'b1);
    chk("tm_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("tm_hi_dom", dom_rst_no, 4'b1111);
    chk("tm_hi_done", done, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("tm_lo2_dom", dom_rst_no, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    test_mode = 1'b0;
    #1;
    chk("tm_off_dom", dom_rst_no, 4'b0000);
    chk("tm_off_done", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
